// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the change scheduler.
//   Return-code encodings, return-code -> tens conversion, one-hot coin
//   encodings (bit 2 = 50, bit 1 = 20, bit 0 = 10), coin values in tens,
//   and the scheduler FSM state encoding.
`timescale 1ns/1ps
package vend_pkg;

    localparam logic [2:0] RET_0       = 3'b000;
    localparam logic [2:0] RET_20      = 3'b001;
    localparam logic [2:0] RET_30      = 3'b010;
    localparam logic [2:0] RET_40      = 3'b011;
    localparam logic [2:0] RET_50      = 3'b100;
    localparam logic [2:0] RET_70      = 3'b101;
    localparam logic [2:0] RET_90      = 3'b110;
    localparam logic [2:0] RET_ILLEGAL = 3'b111;

    localparam logic [2:0] COIN_50 = 3'b100;
    localparam logic [2:0] COIN_20 = 3'b010;
    localparam logic [2:0] COIN_10 = 3'b001;

    localparam logic [3:0] VAL_50 = 4'd5;
    localparam logic [3:0] VAL_20 = 4'd2;
    localparam logic [3:0] VAL_10 = 4'd1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VEND  = 3'd1,
        ST_EJECT = 3'd2,
        ST_GAP   = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    // Change amount in units of ten for a return code.
    function automatic logic [3:0] ret_to_tens(input logic [2:0] ret);
        logic [3:0] tens;
        case (ret)
            RET_20:  tens = 4'd2;
            RET_30:  tens = 4'd3;
            RET_40:  tens = 4'd4;
            RET_50:  tens = 4'd5;
            RET_70:  tens = 4'd7;
            RET_90:  tens = 4'd9;
            default: tens = 4'd0;
        endcase
        return tens;
    endfunction

endpackage

// File: rtl/vend_txn_fifo.sv
// vend_txn_fifo: small FIFO holding pending {purchase, ret} outcomes.
//   clk, reset  : clock, asynchronous active-high reset
//   push, wdata : write strobe and data (ignored while full)
//   pop, rdata  : read strobe and head-of-queue data (head visible without a pop)
//   full, empty : registered status flags
// DEPTH must be a power of two so the pointers wrap naturally.
`timescale 1ns/1ps
module vend_txn_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    // Status flags are registered, so a pop cannot open a slot for a push
    // arriving in the same cycle.
    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_q == AW'(gi))) mem_q[gi] <= wdata;
            end
        end
    endgenerate

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/vend_change_scheduler.sv
// vend_change_scheduler: queues vending outcomes and plays them out as one
// product-release handshake followed by greedy 50/20/10 coin ejections.
//   clk, reset                 : clock, asynchronous active-high reset
//   txn_valid/purchase/ret     : outcome strobe, product flag, 3-bit return code
//   txn_ready                  : outcome can be accepted (FIFO not full, no fault)
//   vend_req/vend_ack          : product release handshake
//   eject_req[2:0]/eject_ack   : one-hot coin request (50/20/10) handshake
//   busy                       : work pending or in progress
//   err_illegal                : one-cycle pulse after return code 111 is offered
//   fault                      : sticky ack timeout / stock exhausted
//   refill, low_stock[2:0]     : coin stock reload and low-stock flags
// Build option VEND_COIN_INVENTORY_EN adds per-denomination stock counters
// with 50 -> 20 -> 10 fallback; without it stock is unlimited.
`timescale 1ns/1ps
module vend_change_scheduler
    import vend_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_CYCLES  = 8,
    parameter int ACK_TIMEOUT = 255,
    parameter int INIT_COINS  = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       txn_valid,
    input  logic       txn_purchase,
    input  logic [2:0] txn_ret,
    output logic       txn_ready,
    output logic       vend_req,
    input  logic       vend_ack,
    output logic [2:0] eject_req,
    input  logic       eject_ack,
    output logic       busy,
    output logic       err_illegal,
    output logic       fault,
    input  logic       refill,
    output logic [2:0] low_stock
);
    localparam int WW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_t        state_q, state_d;
    logic [3:0]    rem_q, rem_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          err_q;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [3:0]    fifo_rdata;
    logic          offer, illegal;
    logic [2:0]    coin_sel;
    logic [3:0]    coin_val;
    logic          coin_fault;
    logic          eject_take;

    assign txn_ready = !fifo_full && (state_q != ST_FAULT);
    assign offer     = txn_valid && txn_ready;
    assign illegal   = offer && (txn_ret == RET_ILLEGAL);
    // A purchase with nothing to return still needs its release handshake;
    // an outcome with neither is simply dropped.
    assign fifo_push = offer && !illegal && (txn_purchase || (txn_ret != RET_0));

    vend_txn_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(4)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({txn_purchase, txn_ret}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign eject_take = (state_q == ST_EJECT) && (rem_q != 4'd0) && !coin_fault && eject_ack;

`ifdef VEND_COIN_INVENTORY_EN
    logic [4:0] stock [3];
    logic       refill_pend_q;
    logic       refill_now;

    // A refill landing while a coin request is held is deferred so the
    // requested denomination cannot change under the hopper.
    assign refill_now = (refill || refill_pend_q) &&
                        !((state_q == ST_EJECT) && (rem_q != 4'd0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) refill_pend_q <= 1'b0;
        else       refill_pend_q <= (refill || refill_pend_q) && !refill_now;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_stock
            logic [4:0] cnt_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)                           cnt_q <= 5'(INIT_COINS);
                else if (refill_now)                 cnt_q <= 5'(INIT_COINS);
                else if (eject_take && coin_sel[gi]) cnt_q <= cnt_q - 5'd1;
            end
            assign stock[gi]     = cnt_q;
            assign low_stock[gi] = (cnt_q <= 5'd2);
        end
    endgenerate

    // Greedy choice with fallback to the next smaller coin when empty.
    always_comb begin
        coin_sel   = COIN_10;
        coin_val   = VAL_10;
        coin_fault = 1'b0;
        if (rem_q >= VAL_50 && stock[2] != 5'd0) begin
            coin_sel = COIN_50;
            coin_val = VAL_50;
        end else if (rem_q >= VAL_20 && stock[1] != 5'd0) begin
            coin_sel = COIN_20;
            coin_val = VAL_20;
        end else if (stock[0] == 5'd0) begin
            coin_fault = 1'b1;
        end
    end
`else
    logic unused_refill;
    assign unused_refill = refill;
    assign low_stock     = 3'b000;

    always_comb begin
        coin_sel   = COIN_10;
        coin_val   = VAL_10;
        coin_fault = 1'b0;
        if (rem_q >= VAL_50) begin
            coin_sel = COIN_50;
            coin_val = VAL_50;
        end else if (rem_q >= VAL_20) begin
            coin_sel = COIN_20;
            coin_val = VAL_20;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= 4'd0;
            wait_q  <= '0;
            gap_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            wait_q  <= wait_d;
            gap_q   <= gap_d;
            err_q   <= illegal;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        wait_d    = wait_q;
        gap_d     = gap_q;
        fifo_pop  = 1'b0;
        vend_req  = 1'b0;
        eject_req = 3'b000;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    rem_d    = ret_to_tens(fifo_rdata[2:0]);
                    wait_d   = '0;
                    state_d  = fifo_rdata[3] ? ST_VEND : ST_EJECT;
                end
            end
            ST_VEND: begin
                vend_req = 1'b1;
                if (vend_ack) begin
                    wait_d  = '0;
                    state_d = ST_EJECT;
                end else if (wait_q == WW'(ACK_TIMEOUT - 1)) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_EJECT: begin
                if (rem_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else if (coin_fault) begin
                    state_d = ST_FAULT;
                end else begin
                    eject_req = coin_sel;
                    if (eject_ack) begin
                        rem_d   = rem_q - coin_val;
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else if (wait_q == WW'(ACK_TIMEOUT - 1)) begin
                        state_d = ST_FAULT;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    wait_d  = '0;
                    state_d = ST_EJECT;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign fault       = (state_q == ST_FAULT);
    assign err_illegal = err_q;

endmodule

// File: tb/tb_vend_change_scheduler.sv
`timescale 1ns/1ps
module tb_vend_change_scheduler;
    localparam int GAP_CYCLES  = 8;
    localparam int ACK_TIMEOUT = 255;
    localparam int INIT_COINS  = 15;
    localparam int FIFO_DEPTH  = 4;
    localparam int EV_VEND     = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       txn_valid = 1'b0, txn_purchase = 1'b0;
    logic [2:0] txn_ret = 3'b000;
    logic       txn_ready, vend_req, busy, err_illegal, fault;
    logic       vend_ack = 1'b0, eject_ack = 1'b0, refill = 1'b0;
    logic [2:0] eject_req, low_stock;

    always #5 clk = ~clk;

    vend_change_scheduler #(
        .FIFO_DEPTH(FIFO_DEPTH), .GAP_CYCLES(GAP_CYCLES),
        .ACK_TIMEOUT(ACK_TIMEOUT), .INIT_COINS(INIT_COINS)
    ) dut (
        .clk(clk), .reset(reset), .txn_valid(txn_valid), .txn_purchase(txn_purchase),
        .txn_ret(txn_ret), .txn_ready(txn_ready), .vend_req(vend_req), .vend_ack(vend_ack),
        .eject_req(eject_req), .eject_ack(eject_ack), .busy(busy), .err_illegal(err_illegal),
        .fault(fault), .refill(refill), .low_stock(low_stock)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Actuator stand-in: acks whichever request is up after a random delay.
    bit auto_ack = 1'b0;
    int resp_dly = 0;
    always @(negedge clk) begin
        vend_ack  = 1'b0;
        eject_ack = 1'b0;
        if (auto_ack && !reset && (vend_req || eject_req != 3'b000)) begin
            if (resp_dly == 0) begin
                if (vend_req) vend_ack = 1'b1;
                else          eject_ack = 1'b1;
                resp_dly = $urandom_range(0, 3);
            end else begin
                resp_dly--;
            end
        end
    end

    function automatic int coin_code(input logic [2:0] e);
        case (e)
            3'b100:  return 5;
            3'b010:  return 2;
            3'b001:  return 1;
            default: return 90 + int'(e);
        endcase
    endfunction

    // Monitor: records every request start, shortest idle run between coin
    // requests, and illegal-code pulses.
    int         obs[$];
    int         low_run = 1000;
    int         min_gap = 1000;
    int         err_cnt = 0;
    logic       prev_v = 1'b0;
    logic [2:0] prev_e = 3'b000;
    always @(negedge clk) begin
        if (reset) begin
            prev_v  = 1'b0;
            prev_e  = 3'b000;
            low_run = 1000;
        end else begin
            if (vend_req && !prev_v) obs.push_back(EV_VEND);
            if (eject_req != 3'b000 && prev_e == 3'b000) begin
                obs.push_back(coin_code(eject_req));
                if (low_run < min_gap) min_gap = low_run;
            end
            if (eject_req == 3'b000) low_run++;
            else                     low_run = 0;
            if (err_illegal) err_cnt++;
            prev_v = vend_req;
            prev_e = eject_req;
        end
    end

    // Reference model: expected actuator events from the outcome rules.
    int exp_q[$];
    int stock[3];

    function automatic int tens_of(input int code);
        case (code)
            1: return 2;
            2: return 3;
            3: return 4;
            4: return 5;
            5: return 7;
            6: return 9;
            default: return 0;
        endcase
    endfunction

    task automatic model_txn(input bit p, input int code);
        int rem;
        int c;
        rem = tens_of(code);
        if (p) exp_q.push_back(EV_VEND);
        while (rem > 0) begin
`ifdef VEND_COIN_INVENTORY_EN
            if (rem >= 5 && stock[2] > 0)      begin c = 5; stock[2]--; end
            else if (rem >= 2 && stock[1] > 0) begin c = 2; stock[1]--; end
            else if (stock[0] > 0)             begin c = 1; stock[0]--; end
            else break;
`else
            if (rem >= 5)      c = 5;
            else if (rem >= 2) c = 2;
            else               c = 1;
`endif
            exp_q.push_back(c);
            rem -= c;
        end
    endtask

    task automatic model_refill();
        for (int i = 0; i < 3; i++) stock[i] = INIT_COINS;
    endtask

    task automatic compare_obs(input string tag, input int base);
        int n;
        n = obs.size() - base;
        check($sformatf("%s_count", tag), n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check($sformatf("%s_ev%0d", tag, i), obs[base + i], exp_q[i]);
        $display("%s: %0d events observed, %0d expected", tag, n, exp_q.size());
        exp_q.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy || vend_req || eject_req != 3'b000) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(n < budget), 1);
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n;
        n = 0;
        while (!txn_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(n < budget), 1);
    endtask

    // Offer one outcome for one cycle; called at a negedge.
    task automatic drive_txn(input bit p, input int code);
        txn_valid    = 1'b1;
        txn_purchase = p;
        txn_ret      = 3'(code);
        @(negedge clk);
        txn_valid = 1'b0;
        $display("txn purchase=%0d ret=%0d", p, code);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_refill();
        @(negedge clk);
    endtask

    int base, err_base, exp_err, n;
    bit p;
    int code;

    initial begin
        model_refill();
        repeat (3) @(negedge clk);
        check("rst_ready", txn_ready, 1);
        check("rst_vend", vend_req, 0);
        check("rst_eject", eject_req, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_err", err_illegal, 0);
        check("rst_low", low_stock, 0);
        reset = 1'b0;
        @(negedge clk);

        // Purchase with 90 back: release, then 50, 20, 20.
        auto_ack = 1'b1;
        base = obs.size();
        min_gap = 1000;
        drive_txn(1'b1, 6);
        check("t1_busy", busy, 1);
        @(negedge clk);
        check("t1_latency_vend", vend_req, 1);
        model_txn(1'b1, 6);
        wait_idle("t1_idle", 2000);
        compare_obs("t1", base);
        check("t1_gap_ok", int'(min_gap >= GAP_CYCLES), 1);
        check("t1_busy_low", busy, 0);

        // Illegal code: one pulse, nothing actuated.
        base = obs.size();
        drive_txn(1'($urandom_range(0, 1)), 7);
        check("t3_err_pulse", err_illegal, 1);
        @(negedge clk);
        check("t3_err_single", err_illegal, 0);
        repeat (20) @(negedge clk);
        check("t3_no_req", obs.size() - base, 0);
        check("t3_not_busy", busy, 0);

        // Stall the FSM in VEND, then offer five outcomes back to back.
        auto_ack = 1'b0;
        base = obs.size();
        drive_txn(1'b1, 0);
        model_txn(1'b1, 0);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            p    = 1'($urandom_range(0, 1));
            code = $urandom_range(1, 6);
            if (k < FIFO_DEPTH) model_txn(p, code);
            txn_valid    = 1'b1;
            txn_purchase = p;
            txn_ret      = 3'(code);
            @(negedge clk);
            $display("t2 offer %0d purchase=%0d ret=%0d", k, p, code);
        end
        txn_valid = 1'b0;
        check("t2_ready_low", txn_ready, 0);
        auto_ack = 1'b1;
        wait_idle("t2_idle", 3000);
        compare_obs("t2", base);
        check("t2_ready_back", txn_ready, 1);

        // Randomised outcomes with random spacing against the model.
        base = obs.size();
        err_base = err_cnt;
        exp_err = 0;
        min_gap = 1000;
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
`ifdef VEND_COIN_INVENTORY_EN
            wait_idle("rnd_idle_pre", 2000);
            refill = 1'b1;
            @(negedge clk);
            refill = 1'b0;
            model_refill();
`endif
            wait_ready("rnd_ready", 3000);
            p    = 1'($urandom_range(0, 1));
            code = $urandom_range(0, 7);
            if (code == 7) exp_err++;
            else if (p || code != 0) model_txn(p, code);
            drive_txn(p, code);
        end
        wait_idle("rnd_idle", 5000);
        repeat (2) @(negedge clk);
        compare_obs("rnd", base);
        check("rnd_err_pulses", err_cnt - err_base, exp_err);
        check("rnd_gap_ok", int'(min_gap >= GAP_CYCLES), 1);

        // Reset in the gap after the 50 of a 70 return: the 20 never comes.
        base = obs.size();
        drive_txn(1'b0, 5);
        n = 0;
        while (eject_req != 3'b100 && n < 50) begin @(negedge clk); n++; end
        check("t5_first_coin_seen", int'(n < 50), 1);
        n = 0;
        while (eject_req != 3'b000 && n < 50) begin @(negedge clk); n++; end
        check("t5_gap_entered", int'(n < 50), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_rst_eject", eject_req, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ready", txn_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        model_refill();
        repeat (40) @(negedge clk);
        exp_q.push_back(5);
        compare_obs("t5", base);

        // Withheld eject_ack: timeout after exactly ACK_TIMEOUT request cycles.
        auto_ack = 1'b0;
        drive_txn(1'b0, 1);
        n = 0;
        while (eject_req == 3'b000 && n < 10) begin @(negedge clk); n++; end
        check("t4_req_seen", eject_req, 3'b010);
        n = 0;
        while (eject_req != 3'b000 && n < 400) begin @(negedge clk); n++; end
        check("t4_timeout_len", n, ACK_TIMEOUT);
        check("t4_fault", fault, 1);
        check("t4_eject_off", eject_req, 0);
        check("t4_ready_off", txn_ready, 0);
        base = obs.size();
        drive_txn(1'b1, 2);
        repeat (5) @(negedge clk);
        check("t4_frozen", obs.size() - base, 0);
        check("t4_fault_sticky", fault, 1);
        do_reset();
        check("t4_fault_cleared", fault, 0);
        check("t4_ready_restored", txn_ready, 1);

`ifdef VEND_COIN_INVENTORY_EN
        // Drain the 50 stock, then 50 back must fall back to 20, 20, 10.
        auto_ack = 1'b1;
        base = obs.size();
        for (int k = 0; k < INIT_COINS; k++) begin
            wait_ready("t6_ready", 3000);
            model_txn(1'b0, 4);
            drive_txn(1'b0, 4);
        end
        wait_idle("t6_drain_idle", 8000);
        compare_obs("t6_drain", base);
        check("t6_low_stock", low_stock,
              (int'(stock[2] <= 2) << 2) | (int'(stock[1] <= 2) << 1) | int'(stock[0] <= 2));
        base = obs.size();
        model_txn(1'b0, 4);
        drive_txn(1'b0, 4);
        wait_idle("t6_fallback_idle", 2000);
        compare_obs("t6_fallback", base);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
